// File: rtl/decoder.sv
`default_nettype none
// ============================================================================
// Module   : decoder
// Purpose  : RV32I(+M) decode stage with a 2-entry skid buffer between fetch
//            and execute; decoder_ready is a pure register output.
// Revision : 1.0  initial release
// ============================================================================
module decoder #(
    parameter bit CHECK_ILLEGAL = 1'b1,
    parameter bit HAS_MUL       = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        fetcher_valid,
    input  logic [31:0] instr,
    input  logic [31:0] fetcher_pc,
    output logic        decoder_ready,
    input  logic        flush,
    input  logic        executor_ready,
    output logic        decoder_valid,
    output logic [31:0] dec_pc,
    output logic [3:0]  dec_op,
    output logic [4:0]  dec_rd,
    output logic [4:0]  dec_rs1,
    output logic [4:0]  dec_rs2,
    output logic [2:0]  dec_funct3,
    output logic        dec_alt,
    output logic        dec_mul,
    output logic [31:0] dec_imm,
    output logic        dec_illegal
);

    typedef struct packed {
        logic [31:0] pc;
        logic [3:0]  op;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  funct3;
        logic        alt;
        logic        mul;
        logic [31:0] imm;
        logic        illegal;
    } dec_t;

    localparam logic [1:0] c_EMPTY = 2'd0;
    localparam logic [1:0] c_ONE   = 2'd1;
    localparam logic [1:0] c_TWO   = 2'd2;

    localparam logic [3:0] c_OP_LUI    = 4'd0;
    localparam logic [3:0] c_OP_AUIPC  = 4'd1;
    localparam logic [3:0] c_OP_JAL    = 4'd2;
    localparam logic [3:0] c_OP_JALR   = 4'd3;
    localparam logic [3:0] c_OP_BRANCH = 4'd4;
    localparam logic [3:0] c_OP_LOAD   = 4'd5;
    localparam logic [3:0] c_OP_STORE  = 4'd6;
    localparam logic [3:0] c_OP_OPIMM  = 4'd7;
    localparam logic [3:0] c_OP_OP     = 4'd8;
    localparam logic [3:0] c_OP_FENCE  = 4'd9;
    localparam logic [3:0] c_OP_SYSTEM = 4'd10;
    localparam logic [3:0] c_OP_NONE   = 4'd15;

    logic [1:0]  r_state;
    logic        r_ready;
    dec_t        r_out;
    dec_t        r_skid;

    logic [1:0]  w_next;
    logic        w_ld_dec;
    logic        w_ld_skid_to_out;
    logic        w_ld_skid;
    logic        w_accept;
    logic        w_consume;
    logic        w_bad;
    dec_t        w_dec;

    logic [6:0]  w_opcode;
    logic [6:0]  w_funct7;
    logic [2:0]  w_f3;
    logic [31:0] w_imm_i;
    logic [31:0] w_imm_s;
    logic [31:0] w_imm_b;
    logic [31:0] w_imm_u;
    logic [31:0] w_imm_j;

    assign w_opcode = instr[6:0];
    assign w_funct7 = instr[31:25];
    assign w_f3     = instr[14:12];
    assign w_imm_i  = {{20{instr[31]}}, instr[31:20]};
    assign w_imm_s  = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    assign w_imm_b  = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    assign w_imm_u  = {instr[31:12], 12'b0};
    assign w_imm_j  = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

    // Opcodes all end in 2'b11, so a non-32-bit encoding falls into the default arm.
    always_comb begin
        w_dec        = '0;
        w_dec.pc     = fetcher_pc;
        w_dec.funct3 = w_f3;
        w_dec.op     = c_OP_NONE;
        w_bad        = 1'b0;
        case (w_opcode)
            7'b0110111: begin
                w_dec.op = c_OP_LUI;   w_dec.rd = instr[11:7]; w_dec.imm = w_imm_u;
            end
            7'b0010111: begin
                w_dec.op = c_OP_AUIPC; w_dec.rd = instr[11:7]; w_dec.imm = w_imm_u;
            end
            7'b1101111: begin
                w_dec.op = c_OP_JAL;   w_dec.rd = instr[11:7]; w_dec.imm = w_imm_j;
            end
            7'b1100111: begin
                w_dec.op  = c_OP_JALR; w_dec.rd = instr[11:7]; w_dec.rs1 = instr[19:15];
                w_dec.imm = w_imm_i;
                w_bad     = (w_f3 != 3'b000);
            end
            7'b1100011: begin
                w_dec.op  = c_OP_BRANCH; w_dec.rs1 = instr[19:15]; w_dec.rs2 = instr[24:20];
                w_dec.imm = w_imm_b;
                w_bad     = (w_f3 == 3'b010) || (w_f3 == 3'b011);
            end
            7'b0000011: begin
                w_dec.op  = c_OP_LOAD; w_dec.rd = instr[11:7]; w_dec.rs1 = instr[19:15];
                w_dec.imm = w_imm_i;
                w_bad     = (w_f3 == 3'b011) || (w_f3 == 3'b110) || (w_f3 == 3'b111);
            end
            7'b0100011: begin
                w_dec.op  = c_OP_STORE; w_dec.rs1 = instr[19:15]; w_dec.rs2 = instr[24:20];
                w_dec.imm = w_imm_s;
                w_bad     = (w_f3[2] || (w_f3 == 3'b011));
            end
            7'b0010011: begin
                w_dec.op  = c_OP_OPIMM; w_dec.rd = instr[11:7]; w_dec.rs1 = instr[19:15];
                w_dec.imm = w_imm_i;
                if (w_f3 == 3'b001) begin
                    w_dec.imm = {27'b0, instr[24:20]};
                    w_bad     = (w_funct7 != 7'b0000000);
                end else if (w_f3 == 3'b101) begin
                    w_dec.imm = {27'b0, instr[24:20]};
                    w_dec.alt = instr[30];
                    w_bad     = (w_funct7 != 7'b0000000) && (w_funct7 != 7'b0100000);
                end
            end
            7'b0110011: begin
                w_dec.op  = c_OP_OP; w_dec.rd = instr[11:7]; w_dec.rs1 = instr[19:15];
                w_dec.rs2 = instr[24:20];
                if (w_funct7 == 7'b0100000) begin
                    w_dec.alt = 1'b1;
                    w_bad     = (w_f3 != 3'b000) && (w_f3 != 3'b101);
                end else if (w_funct7 == 7'b0000001) begin
                    w_dec.mul = HAS_MUL;
                    w_bad     = !HAS_MUL;
                end else begin
                    w_bad     = (w_funct7 != 7'b0000000);
                end
            end
            7'b0001111: begin
                w_dec.op  = c_OP_FENCE; w_dec.rd = instr[11:7]; w_dec.rs1 = instr[19:15];
                w_dec.imm = w_imm_i;
                w_bad     = (w_f3 != 3'b000);
            end
            7'b1110011: begin
                w_dec.op  = c_OP_SYSTEM; w_dec.rd = instr[11:7]; w_dec.rs1 = instr[19:15];
                w_dec.imm = w_imm_i;
                w_bad     = (w_f3 == 3'b100);
            end
            default: w_bad = 1'b1;
        endcase
        // Illegal encodings still flow downstream, but never write a register.
        if (CHECK_ILLEGAL && w_bad) begin
            w_dec.op      = c_OP_NONE;
            w_dec.rd      = 5'd0;
            w_dec.mul     = 1'b0;
            w_dec.illegal = 1'b1;
        end
    end

    assign w_accept  = fetcher_valid && r_ready;
    assign w_consume = (r_state != c_EMPTY) && executor_ready;

    always_comb begin
        w_next           = r_state;
        w_ld_dec         = 1'b0;
        w_ld_skid_to_out = 1'b0;
        w_ld_skid        = 1'b0;
        if (flush) begin
            w_next = c_EMPTY;
        end else begin
            case (r_state)
                c_EMPTY: begin
                    if (w_accept) begin
                        w_next   = c_ONE;
                        w_ld_dec = 1'b1;
                    end
                end
                c_ONE: begin
                    if (w_accept && w_consume) begin
                        w_ld_dec = 1'b1;
                    end else if (w_consume) begin
                        w_next = c_EMPTY;
                    end else if (w_accept) begin
                        w_next    = c_TWO;
                        w_ld_skid = 1'b1;
                    end
                end
                c_TWO: begin
                    if (w_consume) begin
                        w_next           = c_ONE;
                        w_ld_skid_to_out = 1'b1;
                    end
                end
                default: w_next = c_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= c_EMPTY;
            r_ready <= 1'b1;
            r_out   <= '0;
            r_skid  <= '0;
        end else begin
            r_state <= w_next;
            r_ready <= (w_next != c_TWO);
            if (w_ld_dec) begin
                r_out <= w_dec;
            end else if (w_ld_skid_to_out) begin
                r_out <= r_skid;
            end
            if (w_ld_skid) begin
                r_skid <= w_dec;
            end
        end
    end

    assign decoder_ready = r_ready;
    assign decoder_valid = (r_state != c_EMPTY);
    assign dec_pc        = r_out.pc;
    assign dec_op        = r_out.op;
    assign dec_rd        = r_out.rd;
    assign dec_rs1       = r_out.rs1;
    assign dec_rs2       = r_out.rs2;
    assign dec_funct3    = r_out.funct3;
    assign dec_alt       = r_out.alt;
    assign dec_mul       = r_out.mul;
    assign dec_imm       = r_out.imm;
    assign dec_illegal   = r_out.illegal;

endmodule
`default_nettype wire
